// File: rtl/regfile_rename_pkg.sv
// Shared core constants: opcodes and load/store funct3 codes.
// Imported by the register file, decoder and ROB.
package regfile_rename_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_CALC   = 7'b0110011;
  localparam logic [6:0] OP_CALCI  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/regfile_rename_if.sv
// Issue-read, dispatch-rename and commit bundle of the
// renaming register file.
interface regfile_rename_if #(
  parameter int XLEN   = 32,
  parameter int NUM_RD = 2,
  parameter int TAG_W  = 4
);
  import regfile_rename_pkg::*;

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*REG_AW-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;

  logic                     ren_en;
  logic [REG_AW-1:0]        ren_reg;
  logic [TAG_W-1:0]         ren_tag;

  logic                     cm_en;
  logic [REG_AW-1:0]        cm_reg;
  logic [TAG_W-1:0]         cm_tag;
  logic [XLEN-1:0]          cm_data;
  logic [2:0]               cm_ext;
  logic                     cm_load;

  logic                     flush;

  modport master (
    output rd_en, rd_addr,
    output ren_en, ren_reg, ren_tag,
    output cm_en, cm_reg, cm_tag,
    output cm_data, cm_ext, cm_load,
    output flush,
    input  rd_data, rd_busy, rd_tag
  );

  modport slave (
    input  rd_en, rd_addr,
    input  ren_en, ren_reg, ren_tag,
    input  cm_en, cm_reg, cm_tag,
    input  cm_data, cm_ext, cm_load,
    input  flush,
    output rd_data, rd_busy, rd_tag
  );

endinterface

// File: rtl/regfile_rename_load_ext.sv
// Load-width extension of a raw result (LB/LH/LBU/LHU);
// everything else passes through. Shared with LSB forwarding.
module regfile_rename_load_ext
  import regfile_rename_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            load,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  always_comb begin
    dout = din;
    unique case (1'b1)
      load && (funct3 == F3_LB):
        dout = {{(XLEN-8){din[7]}}, din[7:0]};
      load && (funct3 == F3_LH):
        dout = {{(XLEN-16){din[15]}}, din[15:0]};
      load && (funct3 == F3_LBU):
        dout = {{(XLEN-8){1'b0}}, din[7:0]};
      load && (funct3 == F3_LHU):
        dout = {{(XLEN-16){1'b0}}, din[15:0]};
      default:
        dout = din;
    endcase
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy flag and
// producing ROB tag; commit-side bypass on the read ports.
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NUM_RD = 2,
  parameter int TAG_W  = 4
) (
  input logic            clk,
  input logic            rst_n,
  regfile_rename_if.slave bus
);

  logic [XLEN-1:0]  regs [NREG];
  logic [TAG_W-1:0] tags [NREG];
  logic [NREG-1:0]  busy;

  logic [XLEN-1:0]  cm_wdata;
  logic             cm_we;
  logic             ren_we;
  logic             cm_match;

  regfile_rename_load_ext #(
    .XLEN (XLEN)
  ) u_ext (
    .funct3 (bus.cm_ext),
    .load   (bus.cm_load),
    .din    (bus.cm_data),
    .dout   (cm_wdata)
  );

  assign cm_we    = bus.cm_en && (bus.cm_reg != '0);
  assign ren_we   = bus.ren_en && (bus.ren_reg != '0);
  assign cm_match = tags[bus.cm_reg] == bus.cm_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (cm_we)
        regs[bus.cm_reg] <= cm_wdata;
      if (bus.flush) begin
        busy <= '0;
      end else begin
        if (cm_we && cm_match)
          busy[bus.cm_reg] <= 1'b0;
        // a same-cycle rename overrides the clear above
        if (ren_we) begin
          busy[bus.ren_reg] <= 1'b1;
          tags[bus.ren_reg] <= bus.ren_tag;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [REG_AW-1:0] a;
    logic              hit;
    logic [XLEN-1:0]   d_q;
    logic              b_q;
    logic [TAG_W-1:0]  t_q;

    assign a   = bus.rd_addr[p*REG_AW +: REG_AW];
    assign hit = cm_we && (bus.cm_reg == a);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q <= '0;
        b_q <= 1'b0;
        t_q <= '0;
      end else if (bus.rd_en[p]) begin
        d_q <= hit ? cm_wdata : regs[a];
        b_q <= busy[a] && !(hit && cm_match);
        t_q <= tags[a];
      end
    end

    assign bus.rd_data[p*XLEN +: XLEN]  = d_q;
    assign bus.rd_busy[p]               = b_q;
    assign bus.rd_tag[p*TAG_W +: TAG_W] = t_q;
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Directed scoreboard bench for regfile_rename: reads push
// expected results, a monitor pops them when outputs land.
module tb_regfile_rename;

  typedef struct {
    string       n;
    logic [31:0] d;
    logic        b;
    logic [3:0]  t;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  regfile_rename_if #(
    .XLEN   (32),
    .NUM_RD (2),
    .TAG_W  (4)
  ) bus ();

  regfile_rename #(
    .XLEN   (32),
    .NREG   (32),
    .NUM_RD (2),
    .TAG_W  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle();
    bus.rd_en   = '0;
    bus.ren_en  = 1'b0;
    bus.cm_en   = 1'b0;
    bus.cm_load = 1'b0;
    bus.cm_ext  = 3'b0;
    bus.flush   = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  task automatic ren(input int r, input int t);
    bus.ren_en  = 1'b1;
    bus.ren_reg = 5'(r);
    bus.ren_tag = 4'(t);
  endtask

  task automatic cm(input int r, input int t,
                    input logic [31:0] d,
                    input logic ld, input logic [2:0] e);
    bus.cm_en   = 1'b1;
    bus.cm_reg  = 5'(r);
    bus.cm_tag  = 4'(t);
    bus.cm_data = d;
    bus.cm_load = ld;
    bus.cm_ext  = e;
  endtask

  // port 0 must be issued before port 1 within a cycle
  task automatic rd(input int p, input int a,
                    input logic [31:0] d,
                    input logic b, input int t,
                    input string n);
    exp_t e;
    bus.rd_en[p] = 1'b1;
    bus.rd_addr[p*5 +: 5] = 5'(a);
    e.n = n;
    e.d = d;
    e.b = b;
    e.t = 4'(t);
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_data"}, 64'(bus.rd_data), 64'd0);
    chk({n, "_busy"}, 64'(bus.rd_busy), 64'd0);
    chk({n, "_tag"}, 64'(bus.rd_tag), 64'd0);
  endtask

  initial begin : monitor
    logic [1:0] rv;
    exp_t e;
    forever begin
      @(posedge clk);
      rv = rst_n ? bus.rd_en : 2'b00;
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (rv[p]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got output on port %0d expected none", p);
          end else begin
            e = sb.pop_front();
            chk({e.n, "_data"}, 64'(bus.rd_data[p*32 +: 32]), 64'(e.d));
            chk({e.n, "_busy"}, 64'(bus.rd_busy[p]), 64'(e.b));
            chk({e.n, "_tag"}, 64'(bus.rd_tag[p*4 +: 4]), 64'(e.t));
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.rd_addr = '0;
    bus.ren_reg = '0;
    bus.ren_tag = '0;
    bus.cm_reg  = '0;
    bus.cm_tag  = '0;
    bus.cm_data = '0;
    idle();
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    nxt(); rd(0, 5, 0, 0, 0, "x5_p0"); rd(1, 5, 0, 0, 0, "x5_p1");

    nxt(); ren(3, 7);
    nxt(); rd(0, 3, 0, 1, 7, "x3_ren_p0");
           rd(1, 3, 0, 1, 7, "x3_ren_p1");
    nxt(); cm(3, 7, 32'h1234, 0, 3'b000);
    nxt(); rd(0, 3, 32'h1234, 0, 7, "x3_cm");

    nxt(); cm(4, 0, 32'h0000_00F0, 1, 3'b000);
    nxt(); rd(0, 4, 32'hFFFF_FFF0, 0, 0, "lb");
    nxt(); cm(4, 0, 32'h0000_00F0, 1, 3'b100);
    nxt(); rd(0, 4, 32'h0000_00F0, 0, 0, "lbu");
    nxt(); cm(4, 0, 32'h0000_8001, 1, 3'b001);
    nxt(); rd(1, 4, 32'hFFFF_8001, 0, 0, "lh");
    nxt(); cm(10, 0, 32'h1234_8081, 1, 3'b101);
    nxt(); rd(0, 10, 32'h0000_8081, 0, 0, "lhu");
    nxt(); cm(10, 0, 32'h8234_8081, 1, 3'b010);
    nxt(); rd(0, 10, 32'h8234_8081, 0, 0, "lw");
    nxt(); cm(11, 0, 32'h0000_0080, 0, 3'b000);
    nxt(); rd(1, 11, 32'h0000_0080, 0, 0, "noload");
    nxt(); cm(11, 0, 32'hFFFF_0080, 1, 3'b111);
    nxt(); rd(0, 11, 32'hFFFF_0080, 0, 0, "ext111");

    nxt(); ren(6, 2);
    nxt(); ren(6, 5);
    nxt(); cm(6, 2, 32'd9, 0, 3'b000);
    nxt(); rd(0, 6, 32'd9, 1, 5, "stale_cm");
    nxt(); ren(7, 4);
    nxt(); ren(7, 3); cm(7, 4, 32'h77, 0, 3'b000);
    nxt(); rd(0, 7, 32'h77, 1, 3, "ren_cm_same");

    nxt(); cm(8, 0, 32'hAA, 0, 3'b000);
           rd(0, 8, 32'hAA, 0, 0, "byp_p0");
           rd(1, 8, 32'hAA, 0, 0, "byp_p1");
    nxt(); ren(12, 6);
    nxt(); cm(12, 6, 32'h55, 0, 3'b000);
           rd(0, 12, 32'h55, 0, 6, "byp_clr");
    nxt(); cm(6, 2, 32'h99, 0, 3'b000);
           rd(1, 6, 32'h99, 1, 5, "byp_stale");
    nxt(); ren(13, 1); rd(0, 13, 0, 0, 0, "ren_hidden");
    nxt(); rd(0, 13, 0, 1, 1, "ren_later");

    nxt(); cm(0, 0, 32'hDEAD, 0, 3'b000); ren(0, 9);
           rd(0, 0, 0, 0, 0, "x0_byp");
    nxt(); rd(1, 0, 0, 0, 0, "x0_after");

    nxt(); ren(1, 1);
    nxt(); ren(2, 2);
    nxt(); ren(3, 3);
    nxt(); ren(4, 4);
    nxt(); rd(0, 2, 0, 1, 2, "pre_flush");
    nxt(); bus.flush = 1'b1; ren(9, 8); cm(1, 9, 32'h11, 0, 3'b000);
    nxt(); rd(0, 1, 32'h11, 0, 1, "fl_x1");
           rd(1, 9, 0, 0, 0, "fl_x9");
    nxt(); rd(0, 4, 32'hFFFF_8001, 0, 4, "fl_x4");
           rd(1, 3, 32'h1234, 0, 3, "fl_x3");
    nxt(); rd(0, 6, 32'h99, 0, 5, "fl_x6");
           rd(1, 7, 32'h77, 0, 3, "fl_x7");
    nxt(); ren(5, 1);

    nxt();
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);

    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    nxt(); rd(0, 3, 0, 0, 0, "post_rst_x3");
           rd(1, 5, 0, 0, 0, "post_rst_x5");
    nxt();
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain2", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
